// File: rtl/reg_pkg.sv
// Shared register-file types: geometry of the 32x64 file and the queued write entry.
package reg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// In-order write-back FIFO; exposes storage, head pointer and per-entry valid bits
// so the top can search pending results for forwarding.
module wb_fifo
    import reg_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  wb_entry_t        push_entry_i,
    output wb_entry_t        head_entry_o,
    output wb_entry_t        entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o,
    output logic [PTR_W-1:0] head_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: validity is derived purely from head/count.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= push_entry_i;
    end

    always_comb begin
        logic [PTR_W-1:0] off;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PTR_W'(i) - head_q;
            valid_o[i] = {1'b0, off} < count_q;
        end
    end

    assign entries_o    = mem_q;
    assign head_entry_o = mem_q[head_q];
    assign head_ptr_o   = head_q;
    assign count_o      = count_q;
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);

endmodule

// File: rtl/reg_writeback_queue.sv
// Register-file write initiator: queues execute results, issues one write per cycle
// and forwards the youngest pending value for each read port.
module reg_writeback_queue
    import reg_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbValid,
    output logic              wbReady,
    input  logic [ADDR_W-1:0] wbReg,
    input  logic [DATA_W-1:0] wbData,
    input  logic              drainEn,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] fwdReg1,
    output logic              fwdHit1,
    output logic [DATA_W-1:0] fwdData1,
    input  logic [ADDR_W-1:0] fwdReg2,
    output logic              fwdHit2,
    output logic [DATA_W-1:0] fwdData2,
    output logic [CNT_W-1:0]  count,
    output logic              idle
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        head_entry;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head_ptr;
    logic             full, empty;
    logic             push, pop;

    logic              regWrite_q;
    logic [ADDR_W-1:0] writeReg_q;
    logic [DATA_W-1:0] writeData_q;

    // r0 is hard-wired zero: the handshake completes but nothing is stored.
    assign push    = wbValid && !full && (wbReg != '0);
    assign pop     = drainEn && !empty;
    assign wbReady = !full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .pop_i        (pop),
        .push_entry_i ('{addr: wbReg, data: wbData}),
        .head_entry_o (head_entry),
        .entries_o    (entries),
        .valid_o      (valid),
        .head_ptr_o   (head_ptr),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            regWrite_q <= pop;
            if (pop) begin
                writeReg_q  <= head_entry.addr;
                writeData_q <= head_entry.data;
            end
        end
    end

    // Oldest first (write stage, then head..tail-1) so the last match is the youngest.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
        logic [DATA_W:0]  res;
        logic [PTR_W-1:0] idx;
        res = '0;
        if (r != '0) begin
            if (regWrite_q && writeReg_q == r) res = {1'b1, writeData_q};
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_ptr + PTR_W'(k);
                if (valid[idx] && entries[idx].addr == r) res = {1'b1, entries[idx].data};
            end
        end
        return res;
    endfunction

    assign {fwdHit1, fwdData1} = lookup(fwdReg1);
    assign {fwdHit2, fwdData2} = lookup(fwdReg2);

    assign regWrite  = regWrite_q;
    assign writeReg  = writeReg_q;
    assign writeData = writeData_q;
    assign idle      = empty && !regWrite_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a reference queue model and scoreboard.
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbValid, wbReady;
    logic [4:0]  wbReg;
    logic [63:0] wbData;
    logic        drainEn;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [63:0] writeData;
    logic [4:0]  fwdReg1, fwdReg2;
    logic        fwdHit1, fwdHit2;
    logic [63:0] fwdData1, fwdData2;
    logic [2:0]  count;
    logic        idle;

    int checks = 0;
    int errors = 0;

    logic [68:0] sb [$];
    int          exp_count;
    logic        exp_rw;
    logic [4:0]  exp_reg;
    logic [63:0] exp_data;
    logic        acc, iss;
    logic [63:0] rf [32];
    int          rf_writes;

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbValid(wbValid), .wbReady(wbReady), .wbReg(wbReg), .wbData(wbData),
        .drainEn(drainEn),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .fwdReg1(fwdReg1), .fwdHit1(fwdHit1), .fwdData1(fwdData1),
        .fwdReg2(fwdReg2), .fwdHit2(fwdHit2), .fwdData2(fwdData2),
        .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: queue of expected writes plus a register file capturing regWrite.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_count = 0;
            exp_rw    = 1'b0;
            sb.delete();
        end else begin
            acc = wbValid && (exp_count != DEPTH) && (wbReg != 5'd0);
            iss = drainEn && (exp_count != 0);
            if (regWrite) begin
                rf[writeReg] = writeData;
                rf_writes++;
            end
            if (iss) {exp_reg, exp_data} = sb.pop_front();
            exp_rw = iss;
            if (acc) sb.push_back({wbReg, wbData});
            exp_count = exp_count + int'(acc) - int'(iss);
        end
    end

    always @(negedge clk) begin
        chk("count", 64'(count), 64'(exp_count));
        chk("wbReady", 64'(wbReady), 64'(exp_count != DEPTH));
        chk("regWrite", 64'(regWrite), 64'(exp_rw));
        chk("idle", 64'(idle), 64'(exp_count == 0 && !exp_rw));
        if (exp_rw) begin
            chk("writeReg", 64'(writeReg), 64'(exp_reg));
            chk("writeData", writeData, exp_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int snap;
        logic last_ready;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf_writes = 0;
        rst_n = 1'b0; wbValid = 1'b0; wbReg = '0; wbData = '0; drainEn = 1'b0;
        fwdReg1 = '0; fwdReg2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_regWrite", 64'(regWrite), 64'd0);
        chk("rst_writeReg", 64'(writeReg), 64'd0);
        chk("rst_writeData", writeData, 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        rst_n = 1'b1;

        // Single write: accept, issue one edge later, captured the edge after.
        @(negedge clk);
        wbValid = 1'b1; wbReg = 5'd5; wbData = 64'hDEAD_BEEF; drainEn = 1'b1;
        @(negedge clk);
        wbValid = 1'b0;
        chk("single_count", 64'(count), 64'd1);
        chk("single_noissue", 64'(regWrite), 64'd0);
        @(negedge clk);
        chk("single_regWrite", 64'(regWrite), 64'd1);
        chk("single_writeReg", 64'(writeReg), 64'd5);
        @(negedge clk);
        chk("single_rf5", rf[5], 64'hDEAD_BEEF);

        // r0 drop.
        snap = rf_writes;
        wbValid = 1'b1; wbReg = 5'd0; wbData = 64'hFF;
        #1 chk("r0_ready", 64'(wbReady), 64'd1);
        @(negedge clk);
        wbValid = 1'b0;
        chk("r0_count", 64'(count), 64'd0);
        @(negedge clk);
        chk("r0_noissue", 64'(regWrite), 64'd0);
        chk("r0_nowrite", 64'(rf_writes), 64'(snap));

        // Fill with drain held off, then drain in order.
        drainEn = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wbValid = 1'b1; wbReg = 5'(i); wbData = 64'h100 + 64'(i);
            @(negedge clk);
        end
        wbReg = 5'd9; wbData = 64'h999;
        #1 chk("fill_ready", 64'(wbReady), 64'd0);
        chk("fill_count", 64'(count), 64'd4);
        @(negedge clk);
        chk("fill_stall_count", 64'(count), 64'd4);
        wbValid = 1'b0; drainEn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("fill_order", 64'(writeReg), 64'(i));
        end
        @(negedge clk);
        chk("fill_idle", 64'(idle), 64'd1);

        // Forwarding: youngest of two writes to r7, through queue and write stage.
        drainEn = 1'b0;
        wbValid = 1'b1; wbReg = 5'd7; wbData = 64'h11;
        @(negedge clk);
        wbData = 64'h22;
        @(negedge clk);
        wbValid = 1'b0; fwdReg1 = 5'd7; fwdReg2 = 5'd3;
        #1;
        chk("fwd_hit1", 64'(fwdHit1), 64'd1);
        chk("fwd_data1", fwdData1, 64'h22);
        chk("fwd_hit2_miss", 64'(fwdHit2), 64'd0);
        chk("fwd_data2_miss", fwdData2, 64'd0);
        fwdReg1 = 5'd0;
        #1;
        chk("fwd_r0_hit", 64'(fwdHit1), 64'd0);
        chk("fwd_r0_data", fwdData1, 64'd0);
        fwdReg1 = 5'd7; drainEn = 1'b1;
        @(negedge clk);
        drainEn = 1'b0;
        #1 chk("fwd_stage_vs_queue", fwdData1, 64'h22);
        @(negedge clk);
        chk("fwd_held_hit", 64'(fwdHit1), 64'd1);
        chk("fwd_held_data", fwdData1, 64'h22);
        drainEn = 1'b1;
        @(negedge clk);
        #1 chk("fwd_stage_only", fwdData1, 64'h22);
        chk("fwd_stage_only_hit", 64'(fwdHit1), 64'd1);
        @(negedge clk);
        #1 chk("fwd_gone", 64'(fwdHit1), 64'd0);
        chk("rf7_newest", rf[7], 64'h22);

        // Concurrent: fill to full, then drain with the producer held valid.
        drainEn = 1'b0; idx = 10; last_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (wbValid && last_ready) idx++;
            if (idx <= 17) begin
                wbValid = 1'b1; wbReg = 5'(idx); wbData = {32'hC0DE_0000, 32'(idx)};
            end else begin
                wbValid = 1'b0;
            end
            if (c == 4) begin
                #1 chk("conc_full_ready", 64'(wbReady), 64'd0);
                drainEn = 1'b1;
            end
            last_ready = (exp_count != DEPTH);
            @(negedge clk);
        end
        wbValid = 1'b0;
        repeat (DEPTH + 2) @(negedge clk);
        chk("conc_all_issued", 64'(sb.size()), 64'd0);
        chk("conc_idle", 64'(idle), 64'd1);
        chk("conc_rf17", rf[17], {32'hC0DE_0000, 32'd17});
        chk("conc_rf10", rf[10], {32'hC0DE_0000, 32'd10});

        // Reset mid-stream with three queued entries and one write in flight.
        drainEn = 1'b0;
        for (int i = 20; i < 24; i++) begin
            wbValid = 1'b1; wbReg = 5'(i); wbData = 64'(i);
            @(negedge clk);
        end
        wbValid = 1'b0; drainEn = 1'b1;
        @(negedge clk);
        chk("pre_rst_count", 64'(count), 64'd3);
        #3 rst_n = 1'b0;
        #1;
        snap = rf_writes;
        chk("rst_async_regWrite", 64'(regWrite), 64'd0);
        chk("rst_async_count", 64'(count), 64'd0);
        chk("rst_async_idle", 64'(idle), 64'd1);
        chk("rst_async_ready", 64'(wbReady), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_writes", 64'(rf_writes), 64'(snap));
        chk("rst_rf20_untouched", rf[20], 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
